// File: rtl/mpsoc3d_riscv_ahb3_ext_responder.sv
// AHB3-Lite memory responder for the mpsoc3d_riscv external bus port.
// Word-addressed array with byte lanes, configurable wait states and a two-cycle ERROR response.
module mpsoc3d_riscv_ahb3_ext_responder #(
  parameter int              PLEN        = 32,
  parameter int              XLEN        = 32,
  parameter logic [PLEN-1:0] BASE_ADDR   = 'h8000_0000,
  parameter int              MEM_WORDS   = 1024,
  parameter int              WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ahb3_ext_hsel_i,
  input  logic [PLEN-1:0] ahb3_ext_haddr_i,
  input  logic [XLEN-1:0] ahb3_ext_hwdata_i,
  input  logic            ahb3_ext_hwrite_i,
  input  logic [2:0]      ahb3_ext_hsize_i,
  input  logic [2:0]      ahb3_ext_hburst_i,
  input  logic [3:0]      ahb3_ext_hprot_i,
  input  logic [1:0]      ahb3_ext_htrans_i,
  input  logic            ahb3_ext_hmastlock_i,
  output logic [XLEN-1:0] ahb3_ext_hrdata_o,
  output logic            ahb3_ext_hready_o,
  output logic            ahb3_ext_hresp_o
);

  localparam int              AW        = $clog2(MEM_WORDS);
  localparam logic [PLEN-1:0] MEM_BYTES = PLEN'(MEM_WORDS * 4);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic [AW+1:0]   addr_reg;
  logic            write_reg;
  logic [1:0]      size_reg;
  logic [31:0]     ram_q_reg;
  logic [3:0]      fwd_mask_reg;
  logic [31:0]     fwd_data_reg;

  logic [31:0]     mem [MEM_WORDS];

  logic [PLEN-1:0] offset;
  logic            addr_err;
  logic            accept;
  logic [3:0]      be;
  logic            commit;
  logic            from_bus;
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   wr_idx;
  logic            rd_write;
  logic            load_rd;
  logic [3:0]      fwd_mask;
  logic            unused_ok;

  assign unused_ok = ^{ahb3_ext_hburst_i, ahb3_ext_hprot_i, ahb3_ext_hmastlock_i,
                       ahb3_ext_htrans_i[0]};

  assign ahb3_ext_hready_o = (state_reg != S_WAIT) && (state_reg != S_ERR1);
  assign ahb3_ext_hresp_o  = (state_reg == S_ERR1) || (state_reg == S_ERR2);

  // Unsigned wrap makes addresses below the base land far out of range.
  assign offset   = ahb3_ext_haddr_i - BASE_ADDR;
  assign addr_err = (ahb3_ext_hsize_i > 3'd2)
                 || ((ahb3_ext_hsize_i == 3'd1) && ahb3_ext_haddr_i[0])
                 || ((ahb3_ext_hsize_i == 3'd2) && (|ahb3_ext_haddr_i[1:0]))
                 || (offset >= MEM_BYTES);
  assign accept   = ahb3_ext_hsel_i && ahb3_ext_htrans_i[1] && ahb3_ext_hready_o;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_WAIT: begin
        if (cnt_reg <= 4'd1) begin
          state_next = S_DATA;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_ERR1: state_next = S_ERR2;
      default: begin
        if (accept) begin
          if (addr_err) begin
            state_next = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_next = S_DATA;
          end else begin
            state_next = S_WAIT;
            cnt_next   = 4'(WAIT_STATES);
          end
        end else begin
          state_next = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    case (size_reg)
      2'd0:    be = 4'b0001 << addr_reg[1:0];
      2'd1:    be = addr_reg[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign commit = (state_reg == S_DATA) && write_reg && !rst;
  assign wr_idx = addr_reg[AW+1:2];

  // A read entering DATA straight from its address phase takes its address off the bus;
  // when that edge also commits a write to the same word, the new bytes are forwarded.
  assign from_bus = (state_next == S_DATA) && (state_reg != S_WAIT);
  assign rd_idx   = from_bus ? ahb3_ext_haddr_i[AW+1:2] : addr_reg[AW+1:2];
  assign rd_write = from_bus ? ahb3_ext_hwrite_i : write_reg;
  assign load_rd  = (state_next == S_DATA) && !rd_write;
  assign fwd_mask = (commit && (wr_idx == rd_idx)) ? be : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= 4'd0;
      addr_reg     <= '0;
      write_reg    <= 1'b0;
      size_reg     <= 2'd0;
      ram_q_reg    <= 32'd0;
      fwd_mask_reg <= 4'b0000;
      fwd_data_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg  <= ahb3_ext_haddr_i[AW+1:0];
        write_reg <= ahb3_ext_hwrite_i;
        size_reg  <= ahb3_ext_hsize_i[1:0];
      end
      if (state_next == S_ERR1) begin
        ram_q_reg    <= 32'd0;
        fwd_mask_reg <= 4'b0000;
      end else if (load_rd) begin
        ram_q_reg    <= mem[rd_idx];
        fwd_mask_reg <= fwd_mask;
        fwd_data_reg <= ahb3_ext_hwdata_i[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[wr_idx][8*b +: 8] <= ahb3_ext_hwdata_i[8*b +: 8];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign ahb3_ext_hrdata_o[8*gi +: 8] = fwd_mask_reg[gi] ? fwd_data_reg[8*gi +: 8]
                                                             : ram_q_reg[8*gi +: 8];
    end
  endgenerate

endmodule

// File: tb/tb_mpsoc3d_riscv_ahb3_ext_responder.sv
// Directed bench: one responder with no wait states, one with three, sharing the bus signals.
module tb_mpsoc3d_riscv_ahb3_ext_responder;

  localparam logic [31:0] B = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] haddr = '0, hwdata = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd1;
  logic [3:0]  hprot = 4'b0011;
  logic [1:0]  htrans = 2'd0;
  logic        hmastlock = 1'b0;
  logic        hsel0 = 1'b0, hsel3 = 1'b0;
  logic [31:0] rdata0, rdata3;
  logic        ready0, ready3, resp0, resp3;

  logic        sel3 = 1'b0;
  logic [31:0] rdata_s;
  logic        ready_s, resp_s;
  assign rdata_s = sel3 ? rdata3 : rdata0;
  assign ready_s = sel3 ? ready3 : ready0;
  assign resp_s  = sel3 ? resp3  : resp0;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  logic        r1, p1, p2;
  int          cyc;

  always #5 clk = ~clk;

  mpsoc3d_riscv_ahb3_ext_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .ahb3_ext_hsel_i(hsel0), .ahb3_ext_haddr_i(haddr), .ahb3_ext_hwdata_i(hwdata),
    .ahb3_ext_hwrite_i(hwrite), .ahb3_ext_hsize_i(hsize), .ahb3_ext_hburst_i(hburst),
    .ahb3_ext_hprot_i(hprot), .ahb3_ext_htrans_i(htrans), .ahb3_ext_hmastlock_i(hmastlock),
    .ahb3_ext_hrdata_o(rdata0), .ahb3_ext_hready_o(ready0), .ahb3_ext_hresp_o(resp0)
  );

  mpsoc3d_riscv_ahb3_ext_responder #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst),
    .ahb3_ext_hsel_i(hsel3), .ahb3_ext_haddr_i(haddr), .ahb3_ext_hwdata_i(hwdata),
    .ahb3_ext_hwrite_i(hwrite), .ahb3_ext_hsize_i(hsize), .ahb3_ext_hburst_i(hburst),
    .ahb3_ext_hprot_i(hprot), .ahb3_ext_htrans_i(htrans), .ahb3_ext_hmastlock_i(hmastlock),
    .ahb3_ext_hrdata_o(rdata3), .ahb3_ext_hready_o(ready3), .ahb3_ext_hresp_o(resp3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One non-pipelined transfer; returns once hready is high again.
  task automatic xfer(input bit s3, input logic [31:0] addr, input bit wr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdo, output logic rdy1,
                      output logic rsp1, output logic rsp2, output int ncyc);
    sel3 = s3; hsel0 = !s3; hsel3 = s3;
    haddr = addr; hwrite = wr; hsize = size; htrans = 2'd2;
    tick();
    hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'd0; hwdata = wdata;
    rdy1 = ready_s; rsp1 = resp_s; ncyc = 1;
    while (ready_s !== 1'b1 && ncyc < 40) begin
      tick();
      ncyc++;
    end
    rdo = rdata_s; rsp2 = resp_s;
  endtask

  // Pipelined beat on the zero-wait responder; supplies the previous beat's write data.
  task automatic beat0(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                       input logic [31:0] prev_wdata);
    sel3 = 1'b0; hsel0 = 1'b1; htrans = 2'd2;
    haddr = addr; hwrite = wr; hsize = size; hwdata = prev_wdata;
    tick();
  endtask

  logic [31:0] err_addr [4];
  logic [2:0]  err_size [4];

  initial begin
    int lowc, cnt, guard;
    err_addr[0] = B + 32'h1000; err_size[0] = 3'd2;
    err_addr[1] = B - 32'h4;    err_size[1] = 3'd2;
    err_addr[2] = B + 32'h1;    err_size[2] = 3'd1;
    err_addr[3] = B;            err_size[3] = 3'd3;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_ready0", ready0, 1); chk("rst_resp0", resp0, 0); chk("rst_rdata0", rdata0, 0);
    chk("rst_ready3", ready3, 1); chk("rst_resp3", resp3, 0); chk("rst_rdata3", rdata3, 0);
    $display("reset checked");

    beat0(B + 32'h10, 1'b1, 3'd2, 32'h0);
    chk("wr_ready", ready0, 1); chk("wr_resp", resp0, 0);
    beat0(B + 32'h10, 1'b0, 3'd2, 32'hDEADBEEF);
    chk("fwd_word", rdata0, 32'hDEADBEEF); chk("fwd_ready", ready0, 1);
    hsel0 = 1'b0; htrans = 2'd0;
    tick();
    chk("rdata_hold", rdata0, 32'hDEADBEEF);
    $display("word write + forwarded read: rdata=%h", rdata0);

    beat0(B + 32'h20, 1'b1, 3'd2, 32'h0);
    beat0(B + 32'h23, 1'b1, 3'd0, 32'h11223344);
    beat0(B + 32'h20, 1'b0, 3'd2, 32'h5A000000);
    chk("byte_merge", rdata0, 32'h5A223344);
    $display("byte write lane 3: rdata=%h", rdata0);
    beat0(B + 32'h22, 1'b1, 3'd1, 32'h0);
    beat0(B + 32'h20, 1'b0, 3'd2, 32'hBEEF0000);
    chk("half_merge", rdata0, 32'hBEEF3344);
    $display("half write upper: rdata=%h", rdata0);
    hsel0 = 1'b0; htrans = 2'd0;
    tick();

    xfer(1'b0, B,               1'b1, 3'd2, 32'h01020304, rd, r1, p1, p2, cyc);
    xfer(1'b0, B + 32'hFFC,     1'b1, 3'd2, 32'h0BADF00D, rd, r1, p1, p2, cyc);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, err_addr[i], 1'b1, err_size[i], 32'hFFFFFFFF, rd, r1, p1, p2, cyc);
      chk($sformatf("err%0d_ready1", i), r1, 0);
      chk($sformatf("err%0d_resp1", i), p1, 1);
      chk($sformatf("err%0d_resp2", i), p2, 1);
      chk($sformatf("err%0d_cycles", i), cyc, 2);
      chk($sformatf("err%0d_rdata", i), rd, 0);
      $display("error access addr=%h size=%0d cycles=%0d", err_addr[i], err_size[i], cyc);
    end
    xfer(1'b0, B, 1'b0, 3'd2, 32'h0, rd, r1, p1, p2, cyc);
    chk("after_err_w0", rd, 32'h01020304); chk("after_err_lat", cyc, 1); chk("after_err_resp", p2, 0);
    xfer(1'b0, B + 32'hFFC, 1'b0, 3'd2, 32'h0, rd, r1, p1, p2, cyc);
    chk("after_err_top", rd, 32'h0BADF00D);
    xfer(1'b0, B + 32'h20, 1'b0, 3'd2, 32'h0, rd, r1, p1, p2, cyc);
    chk("ram_w20", rd, 32'hBEEF3344);
    $display("array after errors: w0=01020304 top=0BADF00D w20=%h", rd);

    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, B + 32'h40 + 32'(4 * i), 1'b1, 3'd2, 32'hA0000000 + 32'(i), rd, r1, p1, p2, cyc);
      chk($sformatf("ws3_wr%0d_lat", i), cyc, 4);
    end

    sel3 = 1'b1; hsel3 = 1'b1; hwrite = 1'b0; hsize = 3'd2; htrans = 2'd2; haddr = B + 32'h40;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cnt++;
      if (i < 3) begin
        htrans = 2'd3; haddr = B + 32'h40 + 32'(4 * (i + 1));
      end else begin
        hsel3 = 1'b0; htrans = 2'd0;
      end
      lowc = (ready3 === 1'b0) ? 1 : 0;
      guard = 0;
      while (ready3 !== 1'b1 && guard < 20) begin
        tick();
        cnt++;
        guard++;
        if (ready3 === 1'b0) lowc++;
      end
      chk($sformatf("burst%0d_low", i), lowc, 3);
      chk($sformatf("burst%0d_data", i), rdata3, 32'hA0000000 + 32'(i));
      $display("burst beat %0d: low=%0d rdata=%h", i, lowc, rdata3);
    end
    chk("burst_cycles", cnt, 16);

    sel3 = 1'b1; hsel3 = 1'b1; htrans = 2'd2; haddr = B + 32'h40; hwrite = 1'b1; hsize = 3'd2;
    tick();
    chk("rstw_wait_low", ready3, 0);
    hsel3 = 1'b0; htrans = 2'd0; hwdata = 32'hFFFFFFFF; rst = 1'b1;
    tick();
    chk("rstw_ready", ready3, 1); chk("rstw_resp", resp3, 0); chk("rstw_rdata", rdata3, 0);
    rst = 1'b0;
    tick();
    xfer(1'b1, B + 32'h40, 1'b0, 3'd2, 32'h0, rd, r1, p1, p2, cyc);
    chk("rstw_old_data", rd, 32'hA0000000); chk("rstw_lat", cyc, 4);
    $display("reset during write wait: reread=%h", rd);
    xfer(1'b0, B + 32'h10, 1'b0, 3'd2, 32'h0, rd, r1, p1, p2, cyc);
    chk("array_kept", rd, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
